// File: rtl/note_sched_pkg.sv
// Shared types and defaults for the note spawn scheduler.
// State encoding is visible on the top-level state port.
package note_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_PAUSED = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int STATE_W      = 3;
  localparam int NUM_COLS_DEF = 4;
  localparam int NOTES_DEF    = 32;
  localparam int MIN_GAP_DEF  = 2;
  localparam int DRAIN_DEF    = 8;

endpackage

// File: rtl/note_scheduler_rr_pick.sv
// Round-robin picker: first eligible column at or above ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Round controller for the falling-note game: paces spawns per
// tempo tick, enforces per-column spacing, drains and signals done.
module note_scheduler
  import note_sched_pkg::*;
#(
  parameter int NUM_COLS        = NUM_COLS_DEF,
  parameter int NOTES_PER_ROUND = NOTES_DEF,
  parameter int MIN_GAP         = MIN_GAP_DEF,
  parameter int DRAIN_TICKS     = DRAIN_DEF
) (
  input  logic                clkSelect,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  input  logic [NUM_COLS-1:0] req,
  output logic [NUM_COLS-1:0] spawn,
  output logic [STATE_W-1:0]  state,
  output logic [5:0]          notes_left,
  output logic                round_done
);

  localparam int PW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int DW = (DRAIN_TICKS > 0) ? $clog2(DRAIN_TICKS + 1) : 1;

  state_e              state_q;
  state_e              state_d;
  state_e              ret_q;
  logic [5:0]          notes_q;
  logic [PW-1:0]       ptr_q;
  logic [GW-1:0]       gap_q [NUM_COLS];
  logic [DW-1:0]       drain_q;
  logic [NUM_COLS-1:0] spawn_q;
  logic [NUM_COLS-1:0] spawn_d;
  logic                done_q;
  logic                done_d;

  logic [NUM_COLS-1:0] eligible;
  logic                gnt_v;
  logic [PW-1:0]       gnt_idx;
  logic                play_tick;
  logic                drain_tick;
  logic                grant;
  logic                last_note;
  logic                drain_end;
  logic                can_start;

  assign can_start  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign play_tick  = (state_q == ST_PLAY) && tick && !pause;
  assign drain_tick = (state_q == ST_DRAIN) && tick && !pause;
  assign grant      = play_tick && gnt_v;
  assign last_note  = grant && (notes_q <= 6'd1);
  assign drain_end  = drain_tick && (drain_q <= DW'(1));

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      eligible[i] = req[i] && (gap_q[i] == '0);
    end
  end

  rr_pick #(
    .N  (NUM_COLS),
    .PW (PW)
  ) u_pick (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant_valid (gnt_v),
    .grant_idx   (gnt_idx)
  );

  always_ff @(posedge clkSelect or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (pause)          state_d = ST_PAUSED;
        else if (last_note) state_d = ST_DRAIN;
      end
      ST_PAUSED: begin
        if (!pause) state_d = ret_q;
      end
      ST_DRAIN: begin
        if (pause)          state_d = ST_PAUSED;
        else if (drain_end) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spawn_d = '0;
    if (grant) spawn_d[gnt_idx] = 1'b1;
    done_d = (state_q == ST_DRAIN) && (state_d == ST_DONE);
  end

  always_ff @(posedge clkSelect or negedge reset) begin
    if (!reset) begin
      ret_q   <= ST_IDLE;
      notes_q <= '0;
      ptr_q   <= '0;
      drain_q <= '0;
      spawn_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_COLS; i++) begin
        gap_q[i] <= '0;
      end
    end else begin
      spawn_q <= spawn_d;
      done_q  <= done_d;
      if (state_q != ST_PAUSED && state_d == ST_PAUSED) begin
        ret_q <= state_q;
      end
      if (can_start && start) begin
        notes_q <= 6'(NOTES_PER_ROUND);
      end else if (grant && notes_q != '0) begin
        notes_q <= notes_q - 6'd1;
      end
      if (grant) begin
        ptr_q <= (gnt_idx == PW'(NUM_COLS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      // the winner reloads its spacing; everyone else counts down
      if (play_tick) begin
        for (int i = 0; i < NUM_COLS; i++) begin
          if (grant && gnt_idx == PW'(i)) begin
            gap_q[i] <= GW'(MIN_GAP);
          end else if (gap_q[i] != '0) begin
            gap_q[i] <= gap_q[i] - 1'b1;
          end
        end
      end
      if (last_note) begin
        drain_q <= DW'(DRAIN_TICKS);
      end else if (drain_tick && drain_q != '0) begin
        drain_q <= drain_q - 1'b1;
      end
    end
  end

  assign spawn      = spawn_q;
  assign state      = state_q;
  assign notes_left = notes_q;
  assign round_done = done_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: timestamp-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_note_scheduler;
  import note_sched_pkg::*;

  localparam int NC  = 4;
  localparam int NPR = 32;
  localparam int MG  = 2;
  localparam int DT  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          tick = 1'b0;
  logic [NC-1:0] req = '0;
  logic [NC-1:0] spawn;
  logic [2:0]    state;
  logic [5:0]    notes_left;
  logic          round_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  note_scheduler #(
    .NUM_COLS        (NC),
    .NOTES_PER_ROUND (NPR),
    .MIN_GAP         (MG),
    .DRAIN_TICKS     (DT)
  ) dut (
    .clkSelect  (clk),
    .reset      (rst_n),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .req        (req),
    .spawn      (spawn),
    .state      (state),
    .notes_left (notes_left),
    .round_done (round_done)
  );

  // model: a column is free again once more than MG play ticks
  // have passed since its last grant (tick timestamps, not counters)
  typedef struct packed {
    state_e                st;
    state_e                ret;
    int                    notes;
    int                    ptr;
    int                    drain;
    int                    ptc;
    logic [NC-1:0][31:0]   last;
    logic [NC-1:0]         spawn;
    logic                  done;
  } model_t;

  model_t mdl;

  function automatic model_t model_reset();
    model_t m;
    m.st    = ST_IDLE;
    m.ret   = ST_IDLE;
    m.notes = 0;
    m.ptr   = 0;
    m.drain = 0;
    m.ptc   = 0;
    m.spawn = '0;
    m.done  = 1'b0;
    for (int i = 0; i < NC; i++) m.last[i] = 32'(-1000);
    return m;
  endfunction

  function automatic model_t step(input model_t m, input logic s,
                                  input logic p, input logic t,
                                  input logic [NC-1:0] r);
    model_t n;
    int c;
    n = m;
    n.spawn = '0;
    n.done  = 1'b0;
    case (m.st)
      ST_IDLE, ST_DONE: begin
        if (s) begin
          n.st    = ST_PLAY;
          n.notes = NPR;
        end
      end
      ST_PLAY: begin
        if (p) begin
          n.ret = ST_PLAY;
          n.st  = ST_PAUSED;
        end else if (t) begin
          n.ptc = m.ptc + 1;
          for (int k = 0; k < NC; k++) begin
            c = (m.ptr + k) % NC;
            if (n.spawn == '0 && r[c] &&
                (n.ptc - $signed(m.last[c]) > MG)) begin
              n.spawn[c] = 1'b1;
              n.last[c]  = 32'(n.ptc);
              n.ptr      = (c + 1) % NC;
              if (n.notes > 0) n.notes = n.notes - 1;
              if (n.notes == 0) begin
                n.st    = ST_DRAIN;
                n.drain = DT;
              end
            end
          end
        end
      end
      ST_PAUSED: begin
        if (!p) n.st = m.ret;
      end
      ST_DRAIN: begin
        if (p) begin
          n.ret = ST_DRAIN;
          n.st  = ST_PAUSED;
        end else if (t) begin
          n.drain = m.drain - 1;
          if (n.drain <= 0) begin
            n.st   = ST_DONE;
            n.done = 1'b1;
          end
        end
      end
      default: n.st = ST_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= model_reset();
    else        mdl <= step(mdl, start, pause, tick, req);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    chk("m_state", int'(state), int'(mdl.st));
    chk("m_notes", int'(notes_left), mdl.notes);
    chk("m_spawn", int'(spawn), int'(mdl.spawn));
    chk("m_done", int'(round_done), int'(mdl.done));
  end

  task automatic cyc(input logic s, input logic p, input logic t,
                     input logic [NC-1:0] r);
    start = s;
    pause = p;
    tick  = t;
    req   = r;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] exp_d [5];
    int nsp;
    int guard;
    exp_d = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};

    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), ST_IDLE);
    chk("rst_notes", int'(notes_left), 0);
    chk("rst_spawn", int'(spawn), 0);
    chk("rst_done", int'(round_done), 0);
    rst_n = 1'b1;

    cyc(0, 0, 1, 4'b1111);
    chk("idle_tick_ign", int'(state), ST_IDLE);

    cyc(1, 0, 1, 4'b1111);
    chk("start_state", int'(state), ST_PLAY);
    chk("start_notes", int'(notes_left), 32);
    chk("start_tick_nospawn", int'(spawn), 0);

    cyc(0, 0, 1, 4'b1111);
    chk("rr_0", int'(spawn), 4'b0001);
    cyc(0, 0, 1, 4'b1111);
    chk("rr_1", int'(spawn), 4'b0010);
    cyc(0, 0, 1, 4'b1111);
    chk("rr_2", int'(spawn), 4'b0100);
    cyc(0, 0, 1, 4'b1111);
    chk("rr_3", int'(spawn), 4'b1000);
    cyc(0, 0, 0, 4'b0000);
    chk("rr_pulse_end", int'(spawn), 0);
    chk("rr_notes", int'(notes_left), 28);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 4'b0001);
      chk("gap_seq", int'(spawn), int'(exp_d[i]));
    end
    chk("gap_notes", int'(notes_left), 26);

    cyc(0, 1, 1, 4'b1111);
    chk("pause_tick_state", int'(state), ST_PAUSED);
    chk("pause_tick_spawn", int'(spawn), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 4'b1111);
      chk("paused_spawn", int'(spawn), 0);
    end
    chk("paused_notes", int'(notes_left), 26);
    cyc(0, 0, 0, 4'b0000);
    chk("unpause_state", int'(state), ST_PLAY);
    cyc(0, 0, 1, 4'b0001);
    chk("gap_held", int'(spawn), 0);
    cyc(0, 0, 1, 4'b1111);
    chk("ptr_held", int'(spawn), 4'b0010);
    chk("ptr_notes", int'(notes_left), 25);

    nsp   = 0;
    guard = 0;
    while (state == ST_PLAY && guard < 200) begin
      cyc(0, 0, 1, 4'b0011);
      if (spawn != '0) nsp++;
      guard++;
    end
    chk("drain_bound", int'(guard < 200), 1);
    chk("round_spawns", nsp, 25);
    chk("drain_state", int'(state), ST_DRAIN);
    chk("drain_notes", int'(notes_left), 0);

    cyc(1, 0, 0, 4'b1111);
    chk("drain_start_ign", int'(state), ST_DRAIN);
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin
        cyc(0, 1, 1, 4'b0000);
        chk("drain_pause", int'(state), ST_PAUSED);
        cyc(0, 0, 0, 4'b0000);
        chk("drain_resume", int'(state), ST_DRAIN);
      end
      cyc(0, 0, 0, 4'b1111);
      cyc(0, 0, 1, 4'b1111);
      chk("drain_spawn", int'(spawn), 0);
      chk("drain_rdone", int'(round_done), int'(i == 8));
      chk("drain_st", int'(state), (i == 8) ? ST_DONE : ST_DRAIN);
    end
    cyc(0, 0, 0, 4'b0000);
    chk("done_pulse_end", int'(round_done), 0);
    chk("done_state", int'(state), ST_DONE);

    cyc(1, 0, 0, 4'b0000);
    chk("restart_state", int'(state), ST_PLAY);
    chk("restart_notes", int'(notes_left), 32);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 4'b1111);
    chk("mid_notes", int'(notes_left), 17);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), ST_IDLE);
    chk("arst_notes", int'(notes_left), 0);
    chk("arst_spawn", int'(spawn), 0);
    chk("arst_done", int'(round_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 4'b1111);
    chk("post_rst_idle", int'(state), ST_IDLE);
    chk("post_rst_spawn", int'(spawn), 0);
    cyc(1, 0, 0, 4'b0000);
    cyc(0, 0, 1, 4'b0100);
    chk("post_rst_grant", int'(spawn), 4'b0100);
    cyc(0, 0, 0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
